// File: rtl/addsub_accum_pkg.sv
// Shared operation codes for the add/sub/accumulate datapath.
package addsub_accum_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtractor; sub inverts b and feeds carry-in.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;

  assign bx   = b ^ {WIDTH{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign carry    = c[WIDTH];
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used by the ripple-carry core.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_accum.sv
// Registered add/sub/accumulate unit with carry, overflow, sticky overflow
// and a saturating count of accepted operations.
module addsub_accum
  import addsub_accum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 in_valid,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     A_in,
  input  logic [WIDTH-1:0]     B_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     S,
  output logic                 carry,
  output logic                 overflow,
  output logic                 ovf_sticky,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] op_count
);

  logic signed [WIDTH-1:0] opa_p0;
  logic signed [WIDTH-1:0] opb_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic                    sub_p0;
  logic                    acc_p0;
  logic                    carry_p0;
  logic                    ovf_p0;

  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic signed [WIDTH-1:0] s_p1;
  logic                    carry_p1;
  logic                    ovf_p1;
  logic                    sticky_p1;
  logic                    vld_p1;
  logic [CNT_WIDTH-1:0]    cnt_p1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == {CNT_WIDTH{1'b1}}) return cnt;
    return cnt + 1'b1;
  endfunction

  // Stage p0: decode and operand selection; accumulate ops feed back the result
  always_comb begin
    acc_p0 = 1'b0;
    sub_p0 = 1'b0;
    unique case (op)
      OP_ADD:     begin end
      OP_SUB:     sub_p0 = 1'b1;
      OP_ACC_ADD: acc_p0 = 1'b1;
      OP_ACC_SUB: begin
        acc_p0 = 1'b1;
        sub_p0 = 1'b1;
      end
    endcase
  end

  assign opa_p0 = acc_p0 ? s_p1 : A_in;
  assign opb_p0 = B_in;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a        (opa_p0),
    .b        (opb_p0),
    .sub      (sub_p0),
    .sum      (sum_p0),
    .carry    (carry_p0),
    .overflow (ovf_p0)
  );

  // Stage p1: result registers; clear beats a same-cycle operation
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_p1      <= '0;
      b_p1      <= '0;
      s_p1      <= '0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      cnt_p1    <= '0;
    end else if (clear) begin
      a_p1      <= '0;
      b_p1      <= '0;
      s_p1      <= '0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      cnt_p1    <= '0;
    end else if (in_valid) begin
      a_p1      <= opa_p0;
      b_p1      <= opb_p0;
      s_p1      <= sum_p0;
      carry_p1  <= carry_p0;
      ovf_p1    <= ovf_p0;
      sticky_p1 <= sticky_p1 | ovf_p0;
      vld_p1    <= 1'b1;
      cnt_p1    <= sat_inc(cnt_p1);
    end else begin
      vld_p1    <= 1'b0;
    end
  end

  assign A          = a_p1;
  assign B          = b_p1;
  assign S          = s_p1;
  assign carry      = carry_p1;
  assign overflow   = ovf_p1;
  assign ovf_sticky = sticky_p1;
  assign out_valid  = vld_p1;
  assign op_count   = cnt_p1;

endmodule
